// File: rtl/detcond_pkg.sv
// Purpose: shared types and command-header field positions for the detector conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package detcond_pkg;

    // Command FSM: a header byte, optionally followed by a holdoff byte.
    typedef enum logic {
        IDLE        = 1'b0,
        GET_HOLDOFF = 1'b1
    } state_t;

    // Command header layout; bits [7:6] are ignored.
    localparam int CHAN_SEL_LSB = 0;
    localparam int CHAN_SEL_MSB = 3;
    localparam int EN_BIT       = 4;
    localparam int HOLDOFF_BIT  = 5;

endpackage

// File: rtl/det_channel.sv
// Purpose: one detector line: synchroniser, rising-edge detect, enable gate, holdoff dead-time.
// Latency: input edge to det_out/suppressed strobe is SYNC_STAGES+1 cycles.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
//
// Ports: det_in (async raw line), enable/holdoff (static config from the top),
//        det_out (accepted edge strobe), suppressed (edge rejected by holdoff).
module det_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 det_in,
    input  logic                 enable,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 det_out,
    output logic                 suppressed
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [HOLDOFF_W-1:0]   hold_cnt;
    logic                   rise;
    logic                   hold_idle;

    assign rise      = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign hold_idle = (hold_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            edge_q     <= 1'b0;
            hold_cnt   <= '0;
            det_out    <= 1'b0;
            suppressed <= 1'b0;
        end else begin
            // The synchroniser runs regardless of enable so that re-enabling
            // never sees a stale level as a fresh edge.
            sync_q     <= {sync_q[SYNC_STAGES-2:0], det_in};
            edge_q     <= sync_q[SYNC_STAGES-1];
            det_out    <= enable & rise & hold_idle;
            suppressed <= enable & rise & ~hold_idle;

            // A suppressed edge does not extend the dead time; only an
            // accepted edge reloads the counter.
            if (!enable) begin
                hold_cnt <= '0;
            end else if (rise && hold_idle) begin
                hold_cnt <= holdoff;
            end else if (!hold_idle) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/detector_conditioner.sv
// Purpose: conditions NCH async APD lines into clean photon strobes; configured over the command-byte bus.
// Latency: detector edge to det_out SYNC_STAGES+1 cycles; command byte to data_ack 1 cycle, config live 1 cycle later.
// Backpressure: at most one command byte per 2 cycles (data_ack gates the next consume); strobes never stall.
//
// Ports: detectors (raw async lines), mask_bit/data (command byte offer), data_ack (byte consumed pulse),
//        det_out (accepted photon strobes), suppressed (edges rejected by holdoff).
module detector_conditioner
    import detcond_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] detectors,
    input  logic           mask_bit,
    input  logic [7:0]     data,
    output logic           data_ack,
    output logic [NCH-1:0] det_out,
    output logic [NCH-1:0] suppressed
);

    state_t               state_q, state_d;
    logic                 ack_q;
    logic                 consume;
    logic [NCH-1:0]       data_sel;
    logic [NCH-1:0]       hdr_sel_q, hdr_sel_d;
    logic                 hdr_en_q, hdr_en_d;

    // Pending commit, applied during the data_ack cycle so that new config
    // is seen by edges evaluated from the cycle after data_ack rises.
    logic                 cmt_vld_q, cmt_vld_d;
    logic [NCH-1:0]       cmt_sel_q, cmt_sel_d;
    logic                 cmt_en_q, cmt_en_d;
    logic                 cmt_hold_vld_q, cmt_hold_vld_d;
    logic [HOLDOFF_W-1:0] cmt_hold_q, cmt_hold_d;

    logic [NCH-1:0]       enable_q;
    logic [HOLDOFF_W-1:0] holdoff_q [NCH];

    logic                 unused_hdr_bits;

    assign unused_hdr_bits = ^data[7:6];
    assign consume         = mask_bit & ~ack_q;
    assign data_sel        = NCH'(data[CHAN_SEL_MSB:CHAN_SEL_LSB]);
    assign data_ack        = ack_q;

    always_comb begin
        state_d        = state_q;
        hdr_sel_d      = hdr_sel_q;
        hdr_en_d       = hdr_en_q;
        cmt_vld_d      = 1'b0;
        cmt_sel_d      = '0;
        cmt_en_d       = 1'b0;
        cmt_hold_vld_d = 1'b0;
        cmt_hold_d     = '0;
        if (consume) begin
            case (state_q)
                IDLE: begin
                    if (data[HOLDOFF_BIT]) begin
                        hdr_sel_d = data_sel;
                        hdr_en_d  = data[EN_BIT];
                        state_d   = GET_HOLDOFF;
                    end else begin
                        cmt_vld_d = 1'b1;
                        cmt_sel_d = data_sel;
                        cmt_en_d  = data[EN_BIT];
                    end
                end
                GET_HOLDOFF: begin
                    cmt_vld_d      = 1'b1;
                    cmt_sel_d      = hdr_sel_q;
                    cmt_en_d       = hdr_en_q;
                    cmt_hold_vld_d = 1'b1;
                    cmt_hold_d     = HOLDOFF_W'(data);
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ack_q          <= 1'b0;
            hdr_sel_q      <= '0;
            hdr_en_q       <= 1'b0;
            cmt_vld_q      <= 1'b0;
            cmt_sel_q      <= '0;
            cmt_en_q       <= 1'b0;
            cmt_hold_vld_q <= 1'b0;
            cmt_hold_q     <= '0;
            enable_q       <= '1;
            for (int i = 0; i < NCH; i++) begin
                holdoff_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ack_q          <= consume;
            hdr_sel_q      <= hdr_sel_d;
            hdr_en_q       <= hdr_en_d;
            cmt_vld_q      <= cmt_vld_d;
            cmt_sel_q      <= cmt_sel_d;
            cmt_en_q       <= cmt_en_d;
            cmt_hold_vld_q <= cmt_hold_vld_d;
            cmt_hold_q     <= cmt_hold_d;
            if (cmt_vld_q) begin
                for (int i = 0; i < NCH; i++) begin
                    if (cmt_sel_q[i]) begin
                        enable_q[i] <= cmt_en_q;
                        if (cmt_hold_vld_q) begin
                            holdoff_q[i] <= cmt_hold_q;
                        end
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        det_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .HOLDOFF_W   (HOLDOFF_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .det_in     (detectors[i]),
            .enable     (enable_q[i]),
            .holdoff    (holdoff_q[i]),
            .det_out    (det_out[i]),
            .suppressed (suppressed[i])
        );
    end

endmodule

// File: tb/tb_detector_conditioner.sv
`timescale 1ns/1ps
module tb_detector_conditioner;

    localparam int NCH = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LAT = SYNC_STAGES + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] detectors;
    logic           mask_bit;
    logic [7:0]     data;
    logic           data_ack;
    logic [NCH-1:0] det_out;
    logic [NCH-1:0] suppressed;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] det;
        logic [NCH-1:0] sup;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ack_cnt = 0;
    int   ack_base;

    detector_conditioner #(
        .NCH         (NCH),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLDOFF_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .detectors  (detectors),
        .mask_bit   (mask_bit),
        .data       (data),
        .data_ack   (data_ack),
        .det_out    (det_out),
        .suppressed (suppressed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_ack === 1'b1) ack_cnt++;
            if ((det_out | suppressed) !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {24'd0, det_out, suppressed}, 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    check("strobe_cycle", cyc, e_mon.cyc);
                    check("det_out", {28'd0, det_out}, {28'd0, e_mon.det});
                    check("suppressed", {28'd0, suppressed}, {28'd0, e_mon.sup});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive mask high for n cycles; expect one strobe LAT cycles later.
    task automatic pulse(input logic [NCH-1:0] mask, input int n,
                         input logic [NCH-1:0] exp_det, input logic [NCH-1:0] exp_sup);
        exp_t e;
        detectors = mask;
        if ((exp_det | exp_sup) != '0) begin
            e.cyc = cyc + LAT;
            e.det = exp_det;
            e.sup = exp_sup;
            sb.push_back(e);
        end
        idle(n);
        detectors = '0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        int got;
        got = 0;
        mask_bit = 1'b1;
        data = b;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (data_ack === 1'b1) begin
                got = 1;
                break;
            end
        end
        mask_bit = 1'b0;
        check(tag, got, 1);
    endtask

    task automatic drain(input string tag);
        idle(8);
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        detectors = '0;
        mask_bit = 1'b0;
        data = 8'h00;
        idle(3);
        reset = 1'b0;
        check("rst_det_out", {28'd0, det_out}, 32'd0);
        check("rst_suppressed", {28'd0, suppressed}, 32'd0);
        check("rst_data_ack", {31'd0, data_ack}, 32'd0);

        // Ch2 held high for 3 cycles: exactly one strobe.
        pulse(4'b0100, 3, 4'b0100, 4'b0000);
        drain("t1_drain");

        // Enable ch0 with holdoff 4; edges at a, a+2 (suppressed), a+5 (accepted).
        ack_base = ack_cnt;
        send_byte("ack_31", 8'h31);
        send_byte("ack_04", 8'h04);
        idle(2);
        check("t2_ack_count", ack_cnt - ack_base, 2);
        pulse(4'b0001, 1, 4'b0001, 4'b0000);
        idle(1);
        pulse(4'b0001, 1, 4'b0000, 4'b0001);
        idle(2);
        pulse(4'b0001, 1, 4'b0001, 4'b0000);
        drain("t2_drain");

        // Boundary: edge at a+4 still suppressed, a+6 accepted.
        pulse(4'b0001, 1, 4'b0001, 4'b0000);
        idle(3);
        pulse(4'b0001, 1, 4'b0000, 4'b0001);
        idle(1);
        pulse(4'b0001, 1, 4'b0001, 4'b0000);
        drain("t2b_drain");

        // Disable ch1 and ch3.
        ack_base = ack_cnt;
        send_byte("ack_0a", 8'h0A);
        idle(2);
        check("t3_ack_count", ack_cnt - ack_base, 1);
        pulse(4'b1010, 1, 4'b0000, 4'b0000);
        drain("t3_disabled_drain");
        pulse(4'b1111, 1, 4'b0101, 4'b0000);
        drain("t3_drain");

        // Reset between header and holdoff byte: next byte is a fresh header.
        send_byte("ack_3f", 8'h3F);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("mid_rst_det_out", {28'd0, det_out}, 32'd0);
        check("mid_rst_data_ack", {31'd0, data_ack}, 32'd0);
        send_byte("ack_10", 8'h10);
        idle(2);
        pulse(4'b1111, 1, 4'b1111, 4'b0000);
        idle(1);
        pulse(4'b1111, 1, 4'b1111, 4'b0000);
        drain("t4_drain");

        // chan_sel=0 byte, then mask held high for 6 cycles.
        ack_base = ack_cnt;
        send_byte("ack_00", 8'h00);
        idle(2);
        check("t6_single_ack", ack_cnt - ack_base, 1);
        ack_base = ack_cnt;
        mask_bit = 1'b1;
        data = 8'h00;
        idle(6);
        mask_bit = 1'b0;
        idle(3);
        check("t6_held_ack_count", ack_cnt - ack_base, 3);
        pulse(4'b1111, 1, 4'b1111, 4'b0000);
        idle(1);
        pulse(4'b1111, 1, 4'b1111, 4'b0000);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
